// File: rtl/sccb_cfg_pkg.sv
// Shared types and width helpers for the SCCB register-init sequencer.
// Imported by the sequencer top and its timer.
package sccb_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StDelay    = 3'd4,
    StDone     = 3'd5,
    StError    = 3'd6
  } state_e;

  // $clog2 clamped to at least one bit so single-value fields stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sccb_cfg_timer.sv
// Loadable down-counter shared by the delay and timeout states of the sequencer.
// o_expire pulses for one cycle when a loaded count has run down to zero.
module sccb_cfg_timer #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;
  logic             r_armed;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_armed <= 1'b1;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end else begin
      r_armed <= 1'b0;
    end
  end

  assign o_expire = r_armed && (r_count == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the register LUT and issues one SCCB write per entry, with NACK retry,
// busy-handshake timeout, LUT-flagged delay entries and restartable done/error status.
module sccb_cfg_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 166,
  parameter int unsigned IDX_W          = clog2_min1(NUM_REGS),
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned DELAY_CYCLES   = 240000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned RTY_W         = clog2_min1(MAX_RETRY + 1)
) (
  input  logic             S_CLK,
  input  logic             RST,
  input  logic             start_init,
  input  logic             SCCB_busy,
  input  logic             SCCB_nack,
  input  logic             lut_delay,
  output logic             SCCB_req,
  output logic [IDX_W-1:0] LUT_INDEX,
  output logic [RTY_W-1:0] retry_cnt,
  output logic             init_done,
  output logic             init_err
);

  localparam int unsigned TmrW = clog2_min1(max_u(DELAY_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);
  localparam logic [RTY_W-1:0] MaxRty  = RTY_W'(MAX_RETRY);
  localparam logic [TmrW-1:0]  DlyLoad = TmrW'(DELAY_CYCLES);
  // The timer fires one edge after it reaches zero, so a timeout of N cycles loads N-1.
  localparam logic [TmrW-1:0]  TmoLoad = TmrW'(TIMEOUT_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_start_d;
  logic             w_start_edge;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [RTY_W-1:0] r_rty;
  logic [RTY_W-1:0] w_rty_nxt;
  logic             r_req;
  logic             r_done;
  logic             r_err;
  logic             w_advance;
  logic             w_tmr_load;
  logic [TmrW-1:0]  w_tmr_val;
  logic             w_tmr_expire;

  assign w_start_edge = start_init & ~r_start_d;

  sccb_cfg_timer #(
    .WIDTH(TmrW)
  ) u_timer (
    .i_clk     (S_CLK),
    .i_rst     (RST),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_expire  (w_tmr_expire)
  );

  always_ff @(posedge S_CLK or posedge RST) begin
    if (RST) begin
      r_state   <= StIdle;
      r_start_d <= 1'b0;
      r_idx     <= '0;
      r_rty     <= '0;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= start_init;
      r_idx     <= w_idx_nxt;
      r_rty     <= w_rty_nxt;
      r_req     <= (w_state_nxt == StWaitBusy);
      r_done    <= (w_state_nxt == StDone);
      r_err     <= (w_state_nxt == StError);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rty_nxt   = r_rty;
    w_advance   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = TmoLoad;

    unique case (r_state)
      StIdle, StDone, StError: begin
        if (w_start_edge) begin
          w_idx_nxt   = '0;
          w_rty_nxt   = '0;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (lut_delay) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = DlyLoad;
          w_state_nxt = StDelay;
        end else if (!SCCB_busy) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (SCCB_busy) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = StWaitDone;
        end else if (w_tmr_expire) begin
          w_state_nxt = StError;
        end
      end
      StWaitDone: begin
        // Completion is checked before expiry so a same-cycle busy fall counts as done.
        if (!SCCB_busy) begin
          if (!SCCB_nack) begin
            w_advance = 1'b1;
          end else if (r_rty < MaxRty) begin
            w_rty_nxt   = r_rty + 1'b1;
            w_state_nxt = StIssue;
          end else begin
            w_state_nxt = StError;
          end
        end else if (w_tmr_expire) begin
          w_state_nxt = StError;
        end
      end
      StDelay: begin
        if (w_tmr_expire) begin
          w_advance = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_advance) begin
      if (r_idx == LastIdx) begin
        w_state_nxt = StDone;
      end else begin
        w_idx_nxt   = r_idx + 1'b1;
        w_rty_nxt   = '0;
        w_state_nxt = StIssue;
      end
    end
  end

  assign SCCB_req  = r_req;
  assign LUT_INDEX = r_idx;
  assign retry_cnt = r_rty;
  assign init_done = r_done;
  assign init_err  = r_err;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: a randomized SCCB slave responds to requests while a
// list-level model predicts the expected (index, retry) request stream and final status.
module tb_sccb_cfg_sequencer;

  localparam int unsigned NREGS = 4;
  localparam int unsigned MAXR  = 3;
  localparam int unsigned DLY   = 50;
  localparam int unsigned TMO   = 20;

  logic       S_CLK = 1'b0;
  logic       RST;
  logic       start_init;
  logic       SCCB_busy;
  logic       SCCB_nack;
  logic       lut_delay;
  logic       SCCB_req;
  logic [1:0] LUT_INDEX;
  logic [1:0] retry_cnt;
  logic       init_done;
  logic       init_err;

  int total = 0;
  int bad   = 0;

  int             nack_plan[NREGS];
  int             nacks_given[NREGS];
  logic [NREGS-1:0] dly_mask;
  int             q_idx[$];
  int             q_rty[$];
  int             e_idx[$];
  int             e_rty[$];
  int             e_err;
  int             e_last;
  int             e_fr;
  bit             slave_en;
  int             fix_len;
  int             s_phase;
  int             s_cnt;
  int             s_i;

  sccb_cfg_sequencer #(
    .NUM_REGS      (NREGS),
    .MAX_RETRY     (MAXR),
    .DELAY_CYCLES  (DLY),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .S_CLK     (S_CLK),
    .RST       (RST),
    .start_init(start_init),
    .SCCB_busy (SCCB_busy),
    .SCCB_nack (SCCB_nack),
    .lut_delay (lut_delay),
    .SCCB_req  (SCCB_req),
    .LUT_INDEX (LUT_INDEX),
    .retry_cnt (retry_cnt),
    .init_done (init_done),
    .init_err  (init_err)
  );

  always #5 S_CLK = ~S_CLK;

  // Combinational LUT delay flag for the addressed entry.
  always_comb lut_delay = dly_mask[LUT_INDEX];

  // SCCB slave: records each request, raises busy after 0..2 cycles, holds it, then
  // answers NACK while the per-entry NACK budget lasts.
  initial begin
    s_phase = 0;
    s_cnt = 0;
    SCCB_busy = 1'b0;
    SCCB_nack = 1'b0;
    forever begin
      @(negedge S_CLK);
      if (RST || !slave_en) begin
        s_phase = 0;
        SCCB_busy = 1'b0;
        SCCB_nack = 1'b0;
      end else if (s_phase == 0) begin
        if (SCCB_req) begin
          q_idx.push_back(int'(LUT_INDEX));
          q_rty.push_back(int'(retry_cnt));
          s_cnt = $urandom_range(0, 2);
          s_phase = 1;
        end
      end else if (s_phase == 1) begin
        if (s_cnt == 0) begin
          SCCB_busy = 1'b1;
          SCCB_nack = 1'b0;
          s_cnt = (fix_len > 0) ? fix_len : $urandom_range(1, 10);
          s_phase = 2;
        end else begin
          s_cnt--;
        end
      end else begin
        s_cnt--;
        if (s_cnt == 0) begin
          s_i = int'(LUT_INDEX);
          SCCB_nack = (nacks_given[s_i] < nack_plan[s_i]);
          nacks_given[s_i]++;
          SCCB_busy = 1'b0;
          s_phase = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected request stream from the per-entry NACK budget and delay flags.
  task automatic build_expect();
    bit acked;
    e_idx.delete();
    e_rty.delete();
    e_err = 0;
    e_last = 0;
    e_fr = 0;
    for (int i = 0; i < NREGS; i++) begin
      e_last = i;
      if (dly_mask[i]) begin
        e_fr = 0;
        continue;
      end
      acked = 1'b0;
      for (int a = 0; a <= MAXR; a++) begin
        e_idx.push_back(i);
        e_rty.push_back(a);
        e_fr = a;
        if (a >= nack_plan[i]) begin
          acked = 1'b1;
          break;
        end
      end
      if (!acked) begin
        e_err = 1;
        break;
      end
    end
  endtask

  task automatic clear_run();
    q_idx.delete();
    q_rty.delete();
    foreach (nacks_given[i]) nacks_given[i] = 0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(init_done || init_err) && n < 4000) begin
      @(negedge S_CLK);
      n++;
    end
    check({tag, "_finished"}, 32'(init_done || init_err), 1);
  endtask

  task automatic wait_reqs(input string tag, input int cnt);
    int n = 0;
    while (q_idx.size() < cnt && n < 1000) begin
      @(negedge S_CLK);
      n++;
    end
    check({tag, "_reqs_seen"}, 32'(q_idx.size() >= cnt), 1);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_nreq"}, q_idx.size(), e_idx.size());
    for (int i = 0; i < e_idx.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), (i < q_idx.size()) ? q_idx[i] : -1, e_idx[i]);
      check($sformatf("%s_rty%0d", tag, i), (i < q_rty.size()) ? q_rty[i] : -1, e_rty[i]);
    end
    check({tag, "_done"}, 32'(init_done), (e_err == 0) ? 1 : 0);
    check({tag, "_err"}, 32'(init_err), e_err);
    check({tag, "_lut_index"}, 32'(LUT_INDEX), e_last);
    check({tag, "_retry_cnt"}, 32'(retry_cnt), e_fr);
    check({tag, "_req_low"}, 32'(SCCB_req), 0);
  endtask

  task automatic run_seq(input string tag);
    clear_run();
    build_expect();
    start_init = 1'b1;
    @(negedge S_CLK);
    @(negedge S_CLK);
    start_init = 1'b0;
    wait_end(tag);
    compare_run(tag);
  endtask

  initial begin
    int n;
    int n1;
    RST = 1'b1;
    start_init = 1'b0;
    slave_en = 1'b1;
    fix_len = 0;
    dly_mask = '0;
    foreach (nack_plan[i]) nack_plan[i] = 0;
    foreach (nacks_given[i]) nacks_given[i] = 0;

    repeat (3) @(negedge S_CLK);
    check("rst_req", 32'(SCCB_req), 0);
    check("rst_idx", 32'(LUT_INDEX), 0);
    check("rst_rty", 32'(retry_cnt), 0);
    check("rst_done", 32'(init_done), 0);
    check("rst_err", 32'(init_err), 0);
    RST = 1'b0;
    @(negedge S_CLK);

    // All entries acknowledged; a mid-run start pulse must be ignored.
    fix_len = 10;
    clear_run();
    build_expect();
    start_init = 1'b1;
    @(negedge S_CLK);
    check("s1_req_after_k", 32'(SCCB_req), 0);
    check("s1_idx_after_k", 32'(LUT_INDEX), 0);
    @(negedge S_CLK);
    check("s1_req_after_k1", 32'(SCCB_req), 1);
    start_init = 1'b0;
    wait_reqs("s1", 2);
    start_init = 1'b1;
    @(negedge S_CLK);
    start_init = 1'b0;
    wait_end("s1");
    compare_run("s1");

    // Two NACKs on entry 1, then ACK.
    nack_plan = '{0, 2, 0, 0};
    run_seq("s2");

    // Entry 2 always NACKs: retries exhausted.
    nack_plan = '{0, 0, 99, 0};
    run_seq("s3");

    // Slave never answers: request held for exactly the timeout.
    nack_plan = '{0, 0, 0, 0};
    slave_en = 1'b0;
    start_init = 1'b1;
    n = 0;
    while (!SCCB_req && n < 10) begin
      @(negedge S_CLK);
      n++;
    end
    start_init = 1'b0;
    check("s4_req_rose", 32'(SCCB_req), 1);
    n = 0;
    while (SCCB_req && n < 100) begin
      n++;
      @(negedge S_CLK);
    end
    check("s4_req_cycles", n, TMO);
    check("s4_err", 32'(init_err), 1);
    check("s4_done", 32'(init_done), 0);
    check("s4_idx", 32'(LUT_INDEX), 0);
    slave_en = 1'b1;
    @(negedge S_CLK);

    // Delay entry at index 1.
    fix_len = 0;
    dly_mask = 4'b0010;
    clear_run();
    build_expect();
    start_init = 1'b1;
    @(negedge S_CLK);
    start_init = 1'b0;
    n = 0;
    n1 = 0;
    while (!(init_done || init_err) && n < 4000) begin
      if (LUT_INDEX == 2'd1) n1++;
      @(negedge S_CLK);
      n++;
    end
    check("s5_finished", 32'(init_done || init_err), 1);
    check("s5_idx1_cycles", n1, DLY + 2);
    compare_run("s5");

    // Randomized NACK budgets, delay flags and busy lengths.
    for (int r = 0; r < 8; r++) begin
      int v;
      for (int i = 0; i < NREGS; i++) begin
        v = $urandom_range(0, 9);
        nack_plan[i] = (v < 5) ? 0 : (v < 9) ? $urandom_range(1, MAXR) : 99;
      end
      dly_mask = NREGS'($urandom_range(0, 15) & $urandom_range(0, 15));
      run_seq($sformatf("rnd%0d", r));
    end

    // Reset mid-WAIT_DONE with start held high, then level-vs-edge behaviour.
    dly_mask = '0;
    nack_plan = '{0, 0, 0, 0};
    fix_len = 10;
    clear_run();
    start_init = 1'b1;
    n = 0;
    while (!SCCB_busy && n < 50) begin
      @(negedge S_CLK);
      n++;
    end
    check("s7_busy_seen", 32'(SCCB_busy), 1);
    @(negedge S_CLK);
    @(negedge S_CLK);
    RST = 1'b1;
    #1;
    check("s7_rst_req", 32'(SCCB_req), 0);
    check("s7_rst_idx", 32'(LUT_INDEX), 0);
    check("s7_rst_rty", 32'(retry_cnt), 0);
    check("s7_rst_done", 32'(init_done), 0);
    check("s7_rst_err", 32'(init_err), 0);
    @(negedge S_CLK);
    @(negedge S_CLK);
    clear_run();
    build_expect();
    RST = 1'b0;
    wait_end("s7");
    compare_run("s7");
    repeat (60) @(negedge S_CLK);
    check("s7_hold_nreq", q_idx.size(), NREGS);
    check("s7_hold_done", 32'(init_done), 1);
    start_init = 1'b0;
    @(negedge S_CLK);
    run_seq("s7_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_sequencer.md
# sccb_cfg_sequencer

Parametrised successor to the OV7670 register-init sequencer. It walks a register LUT of configurable depth and issues one SCCB write request per entry to the SCCB master. Per-entry NACK retry, busy-handshake timeout, LUT-flagged delay entries and a restartable done/error status are new in this generation. It sits between the camera bring-up control and the SCCB master, and drives the LUT address.

## Interface
- NUM_REGS, 166, number of LUT entries, indices 0..NUM_REGS-1; must be ≥1.
- IDX_W, $clog2(NUM_REGS) (min 1), width of LUT_INDEX.
- MAX_RETRY, 3, extra attempts after a NACK before error; 0 disables retry.
- DELAY_CYCLES, 240000, S_CLK cycles waited on a delay entry.
- TIMEOUT_CYCLES, 65535, max S_CLK cycles in WAIT_BUSY or WAIT_DONE before error.
- S_CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start_init  in  1  level; its rising edge starts or restarts the sequence.
- SCCB_busy  in  1  SCCB master transaction in progress.
- SCCB_nack  in  1  NACK flag of the last transaction; valid when SCCB_busy falls.
- lut_delay  in  1  combinational LUT flag for the entry at LUT_INDEX: wait instead of write.
- SCCB_req  out  1  write request to the SCCB master.
- LUT_INDEX  out  IDX_W  current LUT entry.
- retry_cnt  out  $clog2(MAX_RETRY+1) (min 1)  retries used on the current entry.
- init_done  out  1  sequence completed without error.
- init_err  out  1  sequence aborted; LUT_INDEX holds the failing entry.

## Operation
- Rising-edge detect: start_d is a register; start_edge = start_init & ~start_d.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, DONE, ERROR.
- IDLE: on start_edge, clear LUT_INDEX, retry_cnt, init_done and init_err, then go to ISSUE.
- ISSUE: if lut_delay=1, load the timer with DELAY_CYCLES and go to DELAY. Otherwise, if SCCB_busy=0, set SCCB_req=1, load the timer with TIMEOUT_CYCLES and go to WAIT_BUSY. Otherwise wait in ISSUE.
- WAIT_BUSY: SCCB_req is held at 1. When SCCB_busy=1, set SCCB_req=0, reload the timer with TIMEOUT_CYCLES and go to WAIT_DONE. On timer expiry, go to ERROR.
- WAIT_DONE: on SCCB_busy=0, sample SCCB_nack.
  - NACK with retry_cnt<MAX_RETRY: increment retry_cnt and return to ISSUE on the same index.
  - NACK with retry_cnt=MAX_RETRY: go to ERROR.
  - No NACK: advance.
  - Timer expiry: go to ERROR.
- DELAY: when the timer expires, advance. No request is issued.
- Advance: if LUT_INDEX=NUM_REGS-1, go to DONE. Otherwise increment LUT_INDEX, clear retry_cnt and go to ISSUE.
- DONE: init_done=1. ERROR: init_err=1, with SCCB_req=0. Both states hold until a start_edge, which restarts exactly as from IDLE.
- start_edge during a run (ISSUE to DELAY) is ignored. A level held high never retriggers.
- LUT_INDEX never exceeds NUM_REGS-1 and never wraps.
- Reset, including mid-transaction: state=IDLE and every output 0 (SCCB_req, LUT_INDEX, retry_cnt, init_done, init_err), plus start_d=0 and timer=0.

## Timing
- All outputs are registered.
- start_init first sampled high at edge k: ISSUE after edge k. SCCB_req=1 after edge k+1 if SCCB_busy=0 and lut_delay=0.
- SCCB_req falls on the edge after SCCB_busy is first sampled high. It is never high for less than 1 cycle.
- An entry whose transaction ends at edge m (busy sampled low) gives LUT_INDEX+1 after edge m. The next SCCB_req follows after edge m+1 at the earliest.
- A delay entry entered at edge d advances at edge d+1+DELAY_CYCLES.
- Timeout is exact: ERROR is entered on the TIMEOUT_CYCLES-th cycle without the expected SCCB_busy transition.
- If SCCB_busy falls and the timer expires in the same cycle, busy wins (a normal completion).
- init_done and init_err are mutually exclusive. Each rises on the edge that enters DONE or ERROR respectively.

## Structure
- Package sccb_cfg_pkg holds:
  - the state enum (3-bit encoding);
  - the width helper function for IDX_W and the retry width.
- Sub-module sccb_cfg_timer: a loadable down-counter with a wide enough width (max of DELAY_CYCLES and TIMEOUT_CYCLES) and an expiry pulse. It is shared by DELAY, WAIT_BUSY and WAIT_DONE.

## Test plan
- NUM_REGS=4, SCCB model busy for 10 cycles with no NACK, start pulse: 4 requests on LUT_INDEX 0..3, then init_done=1 with LUT_INDEX=3 and init_err=0.
- NACK on index 1 twice, then ACK, with MAX_RETRY=3: index 1 is issued 3 times with retry_cnt 0→1→2, then index 2 has retry_cnt=0 and init_done=1.
- NACK on index 2 always, with MAX_RETRY=2: 3 attempts, then init_err=1, LUT_INDEX=2 and SCCB_req=0.
- Model never raises SCCB_busy, with TIMEOUT_CYCLES=20: SCCB_req is held for 20 cycles, then init_err=1.
- lut_delay=1 on index 1, with DELAY_CYCLES=50: no SCCB_req for index 1, and index 2 appears 51 cycles after entering DELAY.
- RST asserted mid-WAIT_DONE, then a restart from DONE/ERROR with start held high: all outputs 0 immediately. After release, only one run occurs per rising edge of start_init.
